// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin sequencer of the 4:1 enabled mux.
package mux_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // The mux decodes its input index as {s0,s1}: s0 is index bit 1, s1 is bit 0.
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return {idx[1], idx[0]};
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/grant and mux-control bundle between the requesters, the arbiter and the mux.
interface mux_rr_arbiter_if;
  import mux_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             s0;
  logic             s1;
  logic             e;
  logic             busy;

  // Arbiter side: consumes requests, drives grant and mux controls.
  modport master (
    input  req,
    output gnt, s0, s1, e, busy
  );

  // Requester / mux side.
  modport slave (
    output req,
    input  gnt, s0, s1, e, busy
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Round-robin pick: first asserted request starting one above the last owner.
module rr_pick4 (
  input  logic [3:0] i_req,
  input  logic [1:0] i_last,
  output logic       o_valid,
  output logic [1:0] o_idx
);

  // Scan from the farthest candidate (last itself) to the nearest so the
  // nearest asserted request after last wins.
  always_comb begin
    logic [1:0] w_cand;
    o_valid = |i_req;
    o_idx   = 2'd0;
    w_cand  = 2'd0;
    for (int i = 4; i >= 1; i--) begin
      w_cand = i_last + 2'(i);
      if (i_req[w_cand]) o_idx = w_cand;
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin sequencer for the 4:1 enabled mux: bounded hold time per owner,
// optional dead cycle on every ownership change, all outputs registered.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int DEAD     = 1,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux_rr_arbiter_if.master  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           r_state, w_state;
  logic [3:0]       r_gnt,   w_gnt;
  logic [1:0]       r_sel,   w_sel;
  logic             r_e,     w_e;
  logic             r_busy,  w_busy;
  logic [CNT_W-1:0] r_cnt,   w_cnt;
  logic [1:0]       r_last,  w_last;

  logic             w_pick_vld;
  logic [1:0]       w_pick_idx;
  logic [3:0]       w_own_oh;
  logic             w_release;
  logic             w_preempt;

  rr_pick4 u_pick (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_valid (w_pick_vld),
    .o_idx   (w_pick_idx)
  );

  assign w_own_oh  = 4'b0001 << r_last;
  assign w_release = ~|(bus.req & w_own_oh);
  assign w_preempt = (r_cnt == CNT_MAX) && (|(bus.req & ~w_own_oh));

  // Next-state and next-output decode; the pick result is only consumed when
  // the line is free (IDLE/GAP) or being handed over directly (no dead cycle).
  always_comb begin
    logic w_do_pick;
    w_state   = r_state;
    w_gnt     = r_gnt;
    w_sel     = r_sel;
    w_e       = r_e;
    w_busy    = r_busy;
    w_cnt     = r_cnt;
    w_last    = r_last;
    w_do_pick = 1'b0;

    case (r_state)
      ST_GRANT: begin
        if (w_release || w_preempt) begin
          if (DEAD != 0) begin
            w_state = ST_GAP;
            w_gnt   = 4'b0000;
            w_e     = 1'b0;
            w_busy  = 1'b1;
            w_cnt   = '0;
          end else begin
            w_do_pick = 1'b1;
          end
        end else if (r_cnt != CNT_MAX) begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_do_pick = 1'b1;
    endcase

    if (w_do_pick) begin
      if (w_pick_vld) begin
        w_state = ST_GRANT;
        w_gnt   = 4'b0001 << w_pick_idx;
        w_e     = 1'b1;
        w_busy  = 1'b1;
        w_sel   = idx_to_sel(w_pick_idx);
        w_last  = w_pick_idx;
        w_cnt   = '0;
      end else begin
        w_state = ST_IDLE;
        w_gnt   = 4'b0000;
        w_e     = 1'b0;
        w_busy  = 1'b0;
        w_cnt   = '0;
      end
    end
  end

  // State and output registers; last resets to 3 so requester 0 goes first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_last  <= 2'd3;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_sel   <= w_sel;
      r_e     <= w_e;
      r_busy  <= w_busy;
      r_cnt   <= w_cnt;
      r_last  <= w_last;
    end
  end

  assign bus.gnt  = r_gnt;
  assign bus.s0   = r_sel[1];
  assign bus.s1   = r_sel[0];
  assign bus.e    = r_e;
  assign bus.busy = r_busy;

endmodule
